seg7_scan4: RTL
===============

Name: seg7_scan4

Overview:
- Four-digit multiplexed seven-segment driver for the Basys3 display. It sits directly downstream of the arithmetic/decode logic and replaces the static single-digit drive and hard-wired anode enables.
- It latches a 16-bit hex value plus per-digit decimal-point and blank masks, then time-multiplexes the common anodes.
- A guard interval between digits suppresses ghosting.
- New values are applied only at frame boundaries, so no frame ever shows a torn value.

Parameters:
CLK_HZ, 100000000, input clock frequency in Hz
DIGIT_HZ, 1000, digit-slot rate; DWELL = CLK_HZ/DIGIT_HZ cycles per slot
GUARD_CYCLES, 64, blanked cycles at the start of each slot; must satisfy 0 < GUARD_CYCLES < DWELL

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
value_in  in  16  four hex nibbles; [3:0] is digit 0 (rightmost)
dp_in  in  4  decimal point request per digit, active-high
blank_in  in  4  force digit dark, active-high
load  in  1  single-cycle strobe that captures value_in/dp_in/blank_in
seg_n  out  7  segments {a,b,c,d,e,f,g}, active-low
dp_n  out  1  decimal point, active-low
an_n  out  4  anode enables, active-low; an_n[0] is digit 0
frame_tick  out  1  one-cycle pulse at the start of every frame
pending  out  1  a loaded value is waiting for the next frame boundary

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values (immediate on rst_n low):
  - an_n=4'b1111, seg_n=7'h7F, dp_n=1, frame_tick=0, pending=0
  - active value=0, active dp=0, active blank=4'b1111 (display dark until first load)
  - slot counter=0, digit index=0, state=GUARD
- Registers: pending set {val,dp,blank} and active set {val,dp,blank}.
  - load=1: pending set <= inputs, pending flag <= 1.
  - Multiple loads within one frame: last one wins.
- Slot counter: counts 0..DWELL-1, then wraps.
  - On wrap, the digit index increments mod 4.
  - The cycle where the index wraps 3->0 is the frame boundary.
- Frame boundary actions:
  - If pending=1, copy the pending set to the active set and clear pending.
  - If load is asserted in the same cycle, the inputs bypass straight into the active set and pending stays 0.
  - frame_tick pulses in the first cycle of digit 0's slot.
- FSM, per slot:
  - GUARD while counter < GUARD_CYCLES: an_n=1111, seg_n=7F, dp_n=1.
  - DRIVE for the remaining cycles: an_n has only bit[index] low, unless blank[index]=1, in which case all 1s.
  - In DRIVE, seg_n = font(nibble[index]) and dp_n = ~dp[index].
  - GUARD->DRIVE at counter==GUARD_CYCLES; DRIVE->GUARD on counter wrap.
- Outputs are registered, one cycle after the state/counter they reflect. Every output change is therefore glitch-free, and anodes never overlap.
- Font (active-low, abcdefg), full hex 0-F:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Reset mid-slot: outputs go dark asynchronously. After release, scanning restarts at digit 0, GUARD, counter 0, and the pending value is lost.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: digit k (k=3..1) is blanked when its nibble and all higher nibbles of the active value are 0. Digit 0 is never suppressed. dp_in still lights dp_n on a suppressed digit, with seg_n=7F.
- Undefined: all four nibbles are shown, subject only to blank_in.

Test Plan:
All scenarios use CLK_HZ=1000, DIGIT_HZ=100 (DWELL=10) and GUARD_CYCLES=2.
- Reset release, no load -> an_n=1111 for 80 cycles, frame_tick every 40 cycles, pending=0.
- Load 16'h12AF, dp=0, blank=0 -> from the next frame:
  - digit 0: cycles 0-1 an_n=1111, cycles 2-9 an_n=1110 with seg_n=0111000
  - digit 1: an_n=1101, seg_n=0001000
  - digit 2: seg_n=0010010
  - digit 3: seg_n=1001111
- Load 16'h0008 mid-frame -> pending=1 and the display is unchanged until frame_tick. At frame_tick pending=0 and digit 0 shows 0000000.
- Load 16'h1111, then 16'h2222 in the same frame -> the next frame shows only 2 (seg_n=0010010). Load coincident with the boundary -> the value is displayed that frame, pending stays 0.
- Assert rst_n=0 during digit 2 DRIVE -> an_n=1111 within the same cycle (async). After release, the first DRIVE is digit 0.
- With SEG7_LEADING_ZERO_BLANK_EN, load 16'h0050, dp_in=4'b1000:
  - digit 3: an_n low, seg_n=7F, dp_n=0
  - digit 2: dark
  - digit 1: seg_n=0100100
  - digit 0: seg_n=0000001

Source files
------------

// File: rtl/seg7_scan4_if.sv
// seg7_scan4_if: load-side bus of the seven-segment scanner.
// Carries the value/dp/blank inputs, the load strobe and the pending flag.
interface seg7_scan4_if;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic        load;
    logic        pending;

    modport master (
        output value_in, dp_in, blank_in, load,
        input  pending
    );

    modport slave (
        input  value_in, dp_in, blank_in, load,
        output pending
    );
endinterface

// File: rtl/seg7_scan4.sv
// seg7_scan4: 4-digit multiplexed 7-seg driver with per-slot guard blanking.
// Optional: SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module seg7_scan4 #(
    parameter int CLK_HZ       = 100000000,
    parameter int DIGIT_HZ     = 1000,
    parameter int GUARD_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan4_if.slave bus,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  an_n,
    output logic        frame_tick
);

    localparam int DWELL = CLK_HZ / DIGIT_HZ;
    localparam int CW    = $clog2(DWELL);

    typedef enum logic {
        GUARD,
        DRIVE
    } state_t;

    state_t       state, state_d;
    logic [CW-1:0] cnt;
    logic [1:0]   idx;

    logic [15:0]  pval, aval;
    logic [3:0]   pdp, adp;
    logic [3:0]   pblank, ablank;
    logic         pend;

    logic         last, boundary, sup;
    logic [3:0]   nib;
    logic [3:0]   an_d;
    logic [6:0]   seg_d;
    logic         dp_d;

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: font = 7'b0000001;
            4'h1: font = 7'b1001111;
            4'h2: font = 7'b0010010;
            4'h3: font = 7'b0000110;
            4'h4: font = 7'b1001100;
            4'h5: font = 7'b0100100;
            4'h6: font = 7'b0100000;
            4'h7: font = 7'b0001111;
            4'h8: font = 7'b0000000;
            4'h9: font = 7'b0000100;
            4'hA: font = 7'b0001000;
            4'hB: font = 7'b1100000;
            4'hC: font = 7'b0110001;
            4'hD: font = 7'b1000010;
            4'hE: font = 7'b0110000;
            default: font = 7'b0111000;
        endcase
    endfunction

    assign bus.pending = pend;

    always_comb begin
        last     = (cnt == CW'(DWELL - 1));
        boundary = last && (idx == 2'd3);

        state_d = state;
        if (last)
            state_d = GUARD;
        else if (cnt == CW'(GUARD_CYCLES - 1))
            state_d = DRIVE;

        nib = aval[{idx, 2'b00} +: 4];
        sup = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        unique case (idx)
            2'd3:    sup = (aval[15:12] == 4'h0);
            2'd2:    sup = (aval[15:8] == 8'h00);
            2'd1:    sup = (aval[15:4] == 12'h000);
            default: sup = 1'b0;
        endcase
`endif

        // Segment data follows the digit even when its anode is blanked.
        an_d  = 4'hF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state == DRIVE) begin
            seg_d = sup ? 7'h7F : font(nib);
            dp_d  = ~adp[idx];
            if (!ablank[idx])
                an_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= GUARD;
            cnt   <= '0;
            idx   <= 2'd0;
        end else begin
            state <= state_d;
            cnt   <= last ? '0 : cnt + 1'b1;
            idx   <= last ? idx + 2'd1 : idx;
        end
    end

    // Active set only changes at a frame boundary so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= 1'b0;
            pval   <= 16'h0000;
            pdp    <= 4'h0;
            pblank <= 4'hF;
            aval   <= 16'h0000;
            adp    <= 4'h0;
            ablank <= 4'hF;
        end else if (boundary && bus.load) begin
            aval   <= bus.value_in;
            adp    <= bus.dp_in;
            ablank <= bus.blank_in;
            pend   <= 1'b0;
        end else if (boundary && pend) begin
            aval   <= pval;
            adp    <= pdp;
            ablank <= pblank;
            pend   <= 1'b0;
        end else if (bus.load) begin
            pval   <= bus.value_in;
            pdp    <= bus.dp_in;
            pblank <= bus.blank_in;
            pend   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= 4'hF;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            an_n       <= an_d;
            seg_n      <= seg_d;
            dp_n       <= dp_d;
            frame_tick <= (cnt == '0) && (idx == 2'd0);
        end
    end

endmodule
